fl_netcope_strip: RTL and testbench

FrameLink stage placed directly downstream of the NetCOPE adder. It removes the first frame part (the NetCOPE header part) from every frame and forwards the remaining parts as a well-formed FrameLink frame. It also exports the first header word, and keeps forwarded and dropped frame counters for the software and verification environments.

---
 rtl/fl_netcope_strip_if.sv | 28 ++
 rtl/fl_netcope_strip.sv | 135 +++++++++++++
 tb/tb_fl_netcope_strip.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fl_netcope_strip_if.sv
// FrameLink bus bundle: one word of data, REM, the four active-low
// delimiters and the src/dst ready handshake pair.
//   master : drives data/rem/delimiters/src_rdy_n, receives dst_rdy_n
//   slave  : receives data/rem/delimiters/src_rdy_n, drives dst_rdy_n
interface fl_netcope_strip_if #(
    parameter int DATA_WIDTH = 128
);
    localparam int REM_W = $clog2(DATA_WIDTH / 8);

    logic [DATA_WIDTH-1:0] data;
    logic [REM_W-1:0]      rem;
    logic                  sof_n;
    logic                  sop_n;
    logic                  eop_n;
    logic                  eof_n;
    logic                  src_rdy_n;
    logic                  dst_rdy_n;

    modport master (
        output data, rem, sof_n, sop_n, eop_n, eof_n, src_rdy_n,
        input  dst_rdy_n
    );

    modport slave (
        input  data, rem, sof_n, sop_n, eop_n, eof_n, src_rdy_n,
        output dst_rdy_n
    );
endinterface

// File: rtl/fl_netcope_strip.sv
// fl_netcope_strip: removes the first frame part (NetCOPE header) of every
// FrameLink frame and forwards the remaining parts as a well-formed frame.
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   rx          FrameLink input  (slave)
//   tx          FrameLink output (master), one register stage
//   hdr_data    first word of the most recent non-dropped header part
//   hdr_vld     one-cycle pulse when hdr_data has been updated
//   frame_cnt   forwarded frames (wraps)
//   drop_cnt    header-only frames dropped (saturates at 0xFFFF)
//   err         one-cycle pulse: SOF seen while inside a payload
module fl_netcope_strip #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fl_netcope_strip_if.slave       rx,
    fl_netcope_strip_if.master      tx,
    output logic [DATA_WIDTH-1:0]   hdr_data,
    output logic                    hdr_vld,
    output logic [CNT_WIDTH-1:0]    frame_cnt,
    output logic [15:0]             drop_cnt,
    output logic                    err
);
    localparam int REM_W = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] S_HDR   = 2'd0;
    localparam logic [1:0] S_FIRST = 2'd1;
    localparam logic [1:0] S_BODY  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [1:0]            state_q;
    logic                  tx_vld;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [REM_W-1:0]      tx_rem_q;
    logic                  tx_sof_q, tx_sop_q, tx_eop_q, tx_eof_q;
    logic [DATA_WIDTH-1:0] stage_q;
    // Set between a header's SOF word and its EOP word; without it a stray
    // non-SOF word (e.g. the tail of a frame cut by reset) could be taken
    // as the end of a header.
    logic                  hdr_act_q;

    logic tx_ld, tx_hs, rx_rdy, rx_hs, hdr_word, hdr_live, fwd;

    assign tx_ld    = !tx_vld || !tx.dst_rdy_n;
    assign tx_hs    = tx_vld && !tx.dst_rdy_n;
    // Header words never need the output register, so S_HDR never stalls.
    assign rx_rdy   = (state_q == S_HDR) || tx_ld;
    assign rx_hs    = !rx.src_rdy_n && rx_rdy;
    // A SOF inside a payload restarts header processing for that word.
    assign hdr_word = (state_q == S_HDR) || !rx.sof_n;
    assign hdr_live = hdr_act_q || !rx.sof_n;
    assign fwd      = rx_hs && !hdr_word;

    assign rx.dst_rdy_n = !rx_rdy;

    assign tx.data      = tx_data_q;
    assign tx.rem       = tx_rem_q;
    assign tx.sof_n     = tx_sof_q;
    assign tx.sop_n     = tx_sop_q;
    assign tx.eop_n     = tx_eop_q;
    assign tx.eof_n     = tx_eof_q;
    assign tx.src_rdy_n = !tx_vld;

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_vld    <= 1'b0;
            tx_data_q <= '0;
            tx_rem_q  <= '0;
            tx_sof_q  <= 1'b1;
            tx_sop_q  <= 1'b1;
            tx_eop_q  <= 1'b1;
            tx_eof_q  <= 1'b1;
        end else if (tx_ld) begin
            tx_vld <= fwd;
            if (fwd) begin
                tx_data_q <= rx.data;
                tx_rem_q  <= rx.rem;
                // First payload word opens the output frame and its part.
                tx_sof_q  <= (state_q != S_FIRST);
                tx_sop_q  <= (state_q == S_FIRST) ? 1'b0 : rx.sop_n;
                tx_eop_q  <= rx.eop_n;
                tx_eof_q  <= rx.eof_n;
            end
        end
    end

    // Frame FSM, header capture and drop counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HDR;
            stage_q   <= '0;
            hdr_act_q <= 1'b0;
            hdr_data  <= '0;
            hdr_vld   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            hdr_vld <= 1'b0;
            if (rx_hs && hdr_word) begin
                if (!rx.sof_n)
                    stage_q <= rx.data;
                hdr_act_q <= hdr_live && rx.eop_n;
                state_q   <= S_HDR;
                if (hdr_live && !rx.eop_n) begin
                    if (!rx.eof_n) begin
                        if (drop_cnt != 16'hFFFF)
                            drop_cnt <= drop_cnt + 16'd1;
                    end else begin
                        // Single-word header: staging not yet loaded.
                        hdr_data <= rx.sof_n ? stage_q : rx.data;
                        hdr_vld  <= 1'b1;
                        state_q  <= S_FIRST;
                    end
                end
            end else if (fwd) begin
                state_q <= !rx.eof_n ? S_HDR : S_BODY;
            end
        end
    end

    // Error pulse and forwarded-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            err <= rx_hs && (state_q != S_HDR) && !rx.sof_n;
            if (tx_hs && !tx_eof_q)
                frame_cnt <= frame_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_fl_netcope_strip.sv
module tb_fl_netcope_strip;
    localparam int DW  = 128;
    localparam int RW  = 4;
    localparam int LIM = 2000;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] rem;
        logic          sof, sop, eop, eof;   // active-high in the model
    } fw_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fl_netcope_strip_if #(.DATA_WIDTH(DW)) rx ();
    fl_netcope_strip_if #(.DATA_WIDTH(DW)) tx ();
    fl_netcope_strip_if #(.DATA_WIDTH(DW)) rx4 ();
    fl_netcope_strip_if #(.DATA_WIDTH(DW)) tx4 ();

    logic [DW-1:0] hdr_data, hdr_data4;
    logic          hdr_vld, hdr_vld4, err, err4;
    logic [31:0]   frame_cnt;
    logic [3:0]    frame_cnt4;
    logic [15:0]   drop_cnt, drop_cnt4;

    fl_netcope_strip #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
        .hdr_data(hdr_data), .hdr_vld(hdr_vld), .frame_cnt(frame_cnt),
        .drop_cnt(drop_cnt), .err(err)
    );

    // Narrow-counter copy fed with the same stream, for the wrap check.
    assign rx4.data      = rx.data;
    assign rx4.rem       = rx.rem;
    assign rx4.sof_n     = rx.sof_n;
    assign rx4.sop_n     = rx.sop_n;
    assign rx4.eop_n     = rx.eop_n;
    assign rx4.eof_n     = rx.eof_n;
    assign rx4.src_rdy_n = rx.src_rdy_n;
    assign tx4.dst_rdy_n = tx.dst_rdy_n;

    fl_netcope_strip #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .rx(rx4), .tx(tx4),
        .hdr_data(hdr_data4), .hdr_vld(hdr_vld4), .frame_cnt(frame_cnt4),
        .drop_cnt(drop_cnt4), .err(err4)
    );

    int  tests = 0, fails = 0;
    int  hdr_pulses = 0, err_pulses = 0;
    int  bp_mode = 0;
    fw_t exp_q[$], obs_q[$];
    fw_t mon_w;

    // Reference model state
    int            exp_frames = 0, exp_drops = 0, exp_hdr_pulses = 0, exp_errs = 0;
    logic [DW-1:0] exp_hdr = '0;

    // Output monitor
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if (!tx.src_rdy_n && !tx.dst_rdy_n) begin
                mon_w.data = tx.data;  mon_w.rem = tx.rem;
                mon_w.sof  = !tx.sof_n; mon_w.sop = !tx.sop_n;
                mon_w.eop  = !tx.eop_n; mon_w.eof = !tx.eof_n;
                obs_q.push_back(mon_w);
            end
            if (hdr_vld) hdr_pulses++;
            if (err)     err_pulses++;
        end
    end

    // Downstream ready: always, alternating, or random
    always @(negedge clk) begin
        case (bp_mode)
            0:       tx.dst_rdy_n = 1'b0;
            1:       tx.dst_rdy_n = (tx.dst_rdy_n === 1'b0);
            default: tx.dst_rdy_n = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic fw_t mkw(logic [DW-1:0] d, logic [RW-1:0] r,
                                logic sof, logic sop, logic eop, logic eof);
        fw_t w;
        w.data = d; w.rem = r; w.sof = sof; w.sop = sop; w.eop = eop; w.eof = eof;
        return w;
    endfunction

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send(input fw_t w);
        int   n = 0;
        logic hs;
        rx.data = w.data;  rx.rem = w.rem;
        rx.sof_n = !w.sof; rx.sop_n = !w.sop; rx.eop_n = !w.eop; rx.eof_n = !w.eof;
        rx.src_rdy_n = 1'b0;
        do begin
            #1 hs = !rx.dst_rdy_n;
            @(negedge clk);
            n++;
        end while (!hs && n < LIM);
        rx.src_rdy_n = 1'b1;
        tests++;
        assert (hs) else begin
            fails++;
            $error("FAIL rx_accept: got stalled %0d cycles want accept", n);
        end
    endtask

    // Frame = header part (nh words) + payload parts of a and b words
    // (b=0: one payload part, a=0: header-only). cut>=0 stops after that many
    // payload words. Expected output: the payload parts, SOF on the first word.
    task automatic send_frame(input logic [DW-1:0] h0, input int nh, input int a,
                              input int b, input logic [RW-1:0] lrem, input int cut);
        int   parts[3];
        int   np, k;
        logic stop;
        fw_t  w, e;
        parts = '{nh, a, b};
        np    = (b > 0) ? 3 : ((a > 0) ? 2 : 1);
        k     = 0;
        stop  = 1'b0;
        for (int p = 0; p < np && !stop; p++) begin
            for (int i = 0; i < parts[p] && !stop; i++) begin
                w.sof  = (p == 0 && i == 0);
                w.sop  = (i == 0);
                w.eop  = (i == parts[p] - 1);
                w.eof  = w.eop && (p == np - 1);
                w.data = w.sof ? h0 : rnd();
                w.rem  = w.eof ? lrem : RW'($urandom_range(0, 15));
                if (p > 0) begin
                    if (cut >= 0 && k == cut) begin
                        stop = 1'b1;
                    end else begin
                        e = w;
                        e.sof = (k == 0);
                        exp_q.push_back(e);
                        k++;
                    end
                end
                if (!stop) begin
                    send(w);
                    if (p == 0 && w.eop) begin
                        if (np == 1) begin
                            if (exp_drops < 65535) exp_drops++;
                        end else begin
                            exp_hdr = h0;
                            exp_hdr_pulses++;
                        end
                    end
                end
            end
        end
        if (!stop && np > 1) exp_frames++;
    endtask

    task automatic drain_check(input string tag);
        int  n = 0;
        fw_t o, e;
        while ((obs_q.size() < exp_q.size() || !tx.src_rdy_n) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        tests++;
        assert (n < LIM) else begin
            fails++;
            $error("FAIL %s_drain: got timeout after %0d cycles want drained", tag, n);
        end
        chk({tag, "_tx_count"}, DW'(obs_q.size()), DW'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_tx_data"}, o.data, e.data);
            chk({tag, "_tx_ctl"}, DW'({o.rem, o.sof, o.sop, o.eop, o.eof}),
                                  DW'({e.rem, e.sof, e.sop, e.eop, e.eof}));
        end
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_hdr_data"},   hdr_data, exp_hdr);
        chk({tag, "_hdr_pulses"}, DW'(hdr_pulses), DW'(exp_hdr_pulses));
        chk({tag, "_err_pulses"}, DW'(err_pulses), DW'(exp_errs));
        chk({tag, "_frame_cnt"},  DW'(frame_cnt), DW'(32'(exp_frames)));
        chk({tag, "_frame_cnt4"}, DW'(frame_cnt4), DW'(exp_frames % 16));
        chk({tag, "_drop_cnt"},   DW'(drop_cnt), DW'(exp_drops));
    endtask

    // Assert reset at a negedge, check reset values, clear the model, release.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({tag, "_tx_src_rdy_n"}, DW'(tx.src_rdy_n), DW'(1));
        chk({tag, "_tx_delims"},    DW'({tx.sof_n, tx.sop_n, tx.eop_n, tx.eof_n}), DW'(4'hF));
        chk({tag, "_tx_data"},      tx.data, '0);
        chk({tag, "_tx_rem"},       DW'(tx.rem), '0);
        chk({tag, "_hdr_data"},     hdr_data, '0);
        chk({tag, "_pulses"},       DW'({hdr_vld, err}), '0);
        chk({tag, "_counters"},     DW'({frame_cnt, frame_cnt4, drop_cnt}), '0);
        chk({tag, "_rx_dst_rdy_n"}, DW'(rx.dst_rdy_n), '0);
        obs_q.delete();
        exp_q.delete();
        hdr_pulses = 0; err_pulses = 0;
        exp_frames = 0; exp_drops = 0; exp_hdr_pulses = 0; exp_errs = 0;
        exp_hdr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] a5;
        rst_n = 1'b0;
        rx.src_rdy_n = 1'b1;
        rx.data = '0; rx.rem = '0;
        rx.sof_n = 1'b1; rx.sop_n = 1'b1; rx.eop_n = 1'b1; rx.eof_n = 1'b1;
        a5 = {16{8'hA5}};
        repeat (2) @(negedge clk);
        do_reset("reset0");

        // 3-part frame, TX always ready
        bp_mode = 0;
        send_frame(a5, 1, 2, 3, 4'd7, -1);
        drain_check("three_part");
        chk("three_part_frames", DW'(frame_cnt), DW'(1));

        // Header-only frame is dropped
        send_frame(rnd(), 1, 0, 0, 4'd3, -1);
        drain_check("hdr_only");

        // 650-byte payload with alternating back-pressure
        bp_mode = 1;
        send_frame(rnd(), 1, 41, 0, 4'd9, -1);
        drain_check("bp_650");

        // Random frames, random back-pressure
        bp_mode = 2;
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 9) == 0)
                send_frame(rnd(), $urandom_range(1, 3), 0, 0, RW'($urandom_range(0, 15)), -1);
            else
                send_frame(rnd(), $urandom_range(1, 3), $urandom_range(1, 5),
                           $urandom_range(0, 4), RW'($urandom_range(0, 15)), -1);
        end
        drain_check("random");

        // SOF inside a payload: error pulse, new header stripped
        send_frame(rnd(), 1, 2, 5, 4'd1, 4);
        exp_errs++;
        send_frame(rnd(), 2, 3, 0, 4'd5, -1);
        drain_check("proto_err");

        // 17 frames from reset: 4-bit counter wraps to 1
        bp_mode = 0;
        do_reset("reset1");
        for (int f = 0; f < 17; f++)
            send_frame(rnd(), 1, 1, 0, RW'($urandom_range(0, 15)), -1);
        drain_check("wrap17");
        chk("wrap17_cnt4", DW'(frame_cnt4), DW'(1));

        // Reset mid-payload, stray tail words ignored, next frame clean
        bp_mode = 2;
        send_frame(rnd(), 1, 10, 0, 4'd2, 3);
        do_reset("reset_mid");
        send(mkw(rnd(), 4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        send(mkw(rnd(), 4'd6, 1'b0, 1'b1, 1'b1, 1'b1));
        send_frame(rnd(), 1, 3, 2, 4'd11, -1);
        drain_check("after_reset");

        // Drop counter saturation
        bp_mode = 0;
        for (int f = 0; f < 65540; f++)
            send_frame(rnd(), 1, 0, 0, 4'd0, -1);
        drain_check("drop_sat");
        chk("drop_sat_ffff", DW'(drop_cnt), DW'(16'hFFFF));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
